// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART byte transmitter.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after data).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int DEF_CLK_DIV    = 868;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-around pointers and an extra pointer bit so that
// full and empty can be told apart without a separate occupancy counter.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    // Pointer update; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_byte_tx.sv
// UART transmitter with a small byte FIFO; 8N1 frames, or 8E1 when
// UART_TX_PARITY_EN is defined.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       byte_dv,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = 1;

    tx_state_t     state;
    logic [15:0]   baud_cnt;
    logic [BW-1:0] bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          baud_end;
    logic          push;
    logic          pop;
    logic          line;

    assign baud_end = (baud_cnt == BAUD_LAST);

    // The FSM takes the head byte when idle or at the last STOP cycle,
    // which lets back-to-back frames run without an idle bit.
    assign pop  = rst && ce && !fifo_empty &&
                  ((state == IDLE) || ((state == STOP) && baud_end));
    assign push = rst && ce && byte_dv && (!fifo_full || pop);

    assign busy = (state != IDLE) || !fifo_empty;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (byte_in),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Frame sequencer: each bit period is CLK_DIV enabled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!fifo_empty) begin
                        shift <= fifo_dout;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (!fifo_empty) begin
                            shift <= fifo_dout;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Line level implied by the current state.
    always_comb begin
        line = 1'b1;
        case (state)
            START:  line = 1'b0;
            DATA:   line = shift[bit_cnt];
`ifdef UART_TX_PARITY_EN
            PARITY: line = ^shift;
`endif
            default: line = 1'b1;
        endcase
    end

    // Registered serial output, idle high.
    always_ff @(posedge clk) begin
        if (!rst) tx <= 1'b1;
        else if (ce) tx <= line;
    end

    // One-cycle pulse when an offered byte finds no room.
    always_ff @(posedge clk) begin
        if (!rst) overflow <= 1'b0;
        else overflow <= ce && byte_dv && fifo_full && !pop;
    end

endmodule
